// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC types and widths for the router link and network interfaces.
package noc_pkg;
  localparam int ARRAY_W = 3;
  localparam int VCH_N = 2;
  localparam int VCH_W = $clog2(VCH_N);
  localparam int DATA_W = 32;
  localparam int NODE_W = 2 * ARRAY_W;
  localparam int HLEN_W = 8;
  localparam int HEAD_W = 4 * ARRAY_W + NODE_W + HLEN_W;
  typedef enum logic [1:0] {FT_HEAD, FT_BODY, FT_TAIL, FT_HEADTAIL} ftype_e;
  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL} ni_state_e;
  typedef struct packed {
    logic [DATA_W-HEAD_W-1:0] rsvd;
    logic [ARRAY_W-1:0] dst_x;
    logic [ARRAY_W-1:0] dst_y;
    logic [ARRAY_W-1:0] src_x;
    logic [ARRAY_W-1:0] src_y;
    logic [NODE_W-1:0] src_id;
    logic [HLEN_W-1:0] len;
  } head_fields_t;
  typedef struct packed {
    logic vld;
    logic [VCH_W-1:0] vch;
    ftype_e ftype;
    logic [DATA_W-1:0] data;
  } router_i_t;
endpackage

// File: rtl/noc_ni_tx_if.sv
// noc_ni_tx_if: core-side descriptor and payload-word handshakes into the NI transmitter.
interface noc_ni_tx_if import noc_pkg::*; #(parameter int MAX_LEN = 16);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  logic msg_vld;
  logic msg_rdy;
  logic [ARRAY_W-1:0] msg_dst_x;
  logic [ARRAY_W-1:0] msg_dst_y;
  logic [VCH_W-1:0] msg_vch;
  logic [LEN_W-1:0] msg_len;
  logic wd_vld;
  logic wd_rdy;
  logic [DATA_W-1:0] wd_data;
  modport master(output msg_vld, msg_dst_x, msg_dst_y, msg_vch, msg_len, wd_vld, wd_data,
                 input msg_rdy, wd_rdy);
  modport slave(input msg_vld, msg_dst_x, msg_dst_y, msg_vch, msg_len, wd_vld, wd_data,
                output msg_rdy, wd_rdy);
endinterface

// File: rtl/noc_ni_tx_oreg.sv
// noc_ni_tx_oreg: single-entry flit register; holds its contents until the flit's VC is ready.
module noc_ni_tx_oreg import noc_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  router_i_t din,
  input  logic [VCH_N-1:0] vch_rdy,
  output router_i_t dout,
  output logic acc,
  output logic free
);
  assign acc = dout.vld && vch_rdy[dout.vch];
  assign free = !dout.vld || acc;
  always_ff @(posedge clk)
    if (rst) dout <= '0;
    else if (load) dout <= din;
    else if (acc) dout <= '0;
endmodule

// File: rtl/noc_ni_tx.sv
// noc_ni_tx: packetizes descriptor + payload words into head/body/tail flits for the router local port.
// Optional counters stat_pkts/stat_flits/stat_stall are built when NOC_NI_TX_STATS_EN is defined.
module noc_ni_tx import noc_pkg::*; #(
  parameter int NODEID = 0,
  parameter int MAX_LEN = 16,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  noc_ni_tx_if.slave core,
  output router_i_t flit_o,
  input  logic [VCH_N-1:0] vch_rdy_i,
  input  logic [ARRAY_W-1:0] my_xpos,
  input  logic [ARRAY_W-1:0] my_ypos
`ifdef NOC_NI_TX_STATS_EN
  ,
  output logic [31:0] stat_pkts,
  output logic [31:0] stat_flits,
  output logic [31:0] stat_stall
`endif
);
  ni_state_e state;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] eff_len;
  logic [VCH_W-1:0] vch;
  logic acc;
  logic free;
  logic msg_acc;
  logic wd_acc;
  head_fields_t hf;
  router_i_t din;
  assign eff_len = core.msg_len == '0 ? LEN_W'(1) : core.msg_len;
  // msg_rdy also rises while the tail leaves so the next head follows with no gap
  assign core.msg_rdy = !rst && (state == S_IDLE || (state == S_TAIL && acc));
  assign core.wd_rdy = !rst && (state == S_HEAD || state == S_BODY) && free;
  assign msg_acc = core.msg_vld && core.msg_rdy;
  assign wd_acc = core.wd_vld && core.wd_rdy;
  assign hf = '{rsvd: '0, dst_x: core.msg_dst_x, dst_y: core.msg_dst_y, src_x: my_xpos,
                src_y: my_ypos, src_id: NODE_W'(NODEID), len: HLEN_W'(eff_len)};
  assign din = msg_acc ? router_i_t'{vld: 1'b1, vch: core.msg_vch, ftype: FT_HEAD, data: hf}
                       : router_i_t'{vld: 1'b1, vch: vch, ftype: rem == LEN_W'(1) ? FT_TAIL : FT_BODY,
                                     data: core.wd_data};
  noc_ni_tx_oreg u_oreg (
    .clk(clk), .rst(rst), .load(msg_acc || wd_acc), .din(din),
    .vch_rdy(vch_rdy_i), .dout(flit_o), .acc(acc), .free(free)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      rem <= '0;
      vch <= '0;
    end else begin
      if (msg_acc) begin
        vch <= core.msg_vch;
        rem <= eff_len;
      end else if (wd_acc) rem <= rem - LEN_W'(1);
      state <= msg_acc ? S_HEAD
             : wd_acc ? (rem == LEN_W'(1) ? S_TAIL : S_BODY)
             : (state == S_HEAD && acc) ? S_BODY
             : (state == S_TAIL && acc) ? S_IDLE
             : state;
    end
`ifdef NOC_NI_TX_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      stat_pkts <= '0;
      stat_flits <= '0;
      stat_stall <= '0;
    end else begin
      stat_pkts <= stat_pkts + 32'(acc && flit_o.ftype == FT_TAIL);
      stat_flits <= stat_flits + 32'(acc);
      stat_stall <= stat_stall + 32'(flit_o.vld && !vch_rdy_i[flit_o.vch]);
    end
`endif
endmodule
